// File: rtl/load_store_unit.sv
// Load/store initiator for a word-addressed data memory with a one-cycle registered read.
// Handles sub-word loads (with extension) and sub-word stores (read-modify-write).
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {StIdle, StRead, StCapture, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merge_d;

  always_comb begin
    req_err = 1'b0;
    unique case (funct3)
      3'b000, 3'b100: req_err = 1'b0;
      3'b001, 3'b101: req_err = addr[0];
      3'b010:         req_err = |addr[1:0];
      default:        req_err = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= MEM_WORDS) req_err = 1'b1;
  end

  always_comb begin
    byte_sel = mem_rdata[7:0];
    unique case (addr_q[1:0])
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_val = mem_rdata;
    unique case (funct3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = mem_rdata;
    endcase

    // merge_q still holds the store data when the old word arrives
    merge_d = mem_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      unique case (addr_q[1:0])
        2'd0: merge_d[7:0]   = merge_q[7:0];
        2'd1: merge_d[15:8]  = merge_q[7:0];
        2'd2: merge_d[23:16] = merge_q[7:0];
        2'd3: merge_d[31:24] = merge_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_d[31:16] = merge_q[15:0];
    end else begin
      merge_d[15:0] = merge_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (req_err)                      state_d = StDone;
          else if (we && funct3 == 3'b010)  state_d = StWrite;
          else                              state_d = StRead;
        end
      end
      StRead:    state_d = StCapture;
      StCapture: state_d = we_q ? StWrite : StDone;
      StWrite:   state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      merge_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req) begin
        we_q     <= we;
        funct3_q <= funct3;
        addr_q   <= addr;
        merge_q  <= wdata;
        err_q    <= req_err;
      end
      if (state_q == StCapture) begin
        if (we_q) merge_q <= merge_d;
        else      rdata_q <= load_val;
      end
    end
  end

  always_comb begin
    rdata     = rdata_q;
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    err       = (state_q == StDone) && err_q;
    mem_we    = (state_q == StWrite) && !rst;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (state_q == StRead || state_q == StWrite) mem_addr = {2'b00, addr_q[31:2]};
    if (state_q == StWrite) mem_wdata = merge_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/busy sequences and random ops
// checked against an arithmetic reference model of memory and load results.
module tb_load_store_unit;

  localparam int unsigned Words = 101;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        done, err, busy, mem_we;

  load_store_unit #(.MEM_WORDS(Words)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .err(err), .busy(busy), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory with registered read
  logic [31:0] tb_mem [Words] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_we && mem_addr < Words) tb_mem[mem_addr[6:0]] <= mem_wdata;
    mem_rdata <= (mem_addr < Words) ? tb_mem[mem_addr[6:0]] : 32'h0;
  end

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] ref_mem [Words];
  logic [31:0] ref_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: applies one request to ref_mem/ref_rdata from the architectural rules
  task automatic ref_apply(input logic w, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] d, output logic e, output int lat);
    int unsigned idx, off, sz;
    logic sgn, illegal;
    logic [31:0] v, mask;
    idx = a >> 2;
    off = a % 4;
    sz = 4; sgn = 1'b0; illegal = 1'b0;
    case (f)
      3'b000: begin sz = 1; sgn = 1'b1; end
      3'b100: sz = 1;
      3'b001: begin sz = 2; sgn = 1'b1; end
      3'b101: sz = 2;
      3'b010: sz = 4;
      default: illegal = 1'b1;
    endcase
    e = illegal || (off % sz != 0) || (idx >= Words);
    if (e) begin
      lat = 1;
    end else begin
      mask = (sz == 4) ? 32'hFFFF_FFFF : (sz == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
      if (!w) begin
        v = (ref_mem[idx] >> (8 * off)) & mask;
        if (sgn && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sgn && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
        ref_rdata = v;
        lat = 3;
      end else begin
        ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off))) | ((d & mask) << (8 * off));
        lat = (sz == 4) ? 2 : 4;
      end
    end
  endtask

  // Issue one request and observe it until done (bounded)
  task automatic do_op(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic e,
                       output logic [31:0] rd, output logic b1, output int wr_cnt,
                       output int wr_cyc, output logic [31:0] wr_addr,
                       output logic [31:0] wr_data);
    int cyc;
    @(negedge clk);
    we = w; funct3 = f; addr = a; wdata = d; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    cyc = 1; lat = -1; e = 1'b0; rd = 32'h0; wr_cnt = 0; wr_cyc = -1;
    wr_addr = 32'h0; wr_data = 32'h0; b1 = busy;
    while (cyc <= 10) begin
      if (mem_we) begin
        wr_cnt++; wr_cyc = cyc; wr_addr = mem_addr; wr_data = mem_wdata;
      end
      if (done) begin
        lat = cyc; e = err; rd = rdata;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_check(input string tag, input logic w, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic e, output logic [31:0] rd);
    logic exp_e, b1;
    int exp_lat, wr_cnt, wr_cyc;
    logic [31:0] wr_addr, wr_data;
    ref_apply(w, f, a, d, exp_e, exp_lat);
    do_op(w, f, a, d, lat, e, rd, b1, wr_cnt, wr_cyc, wr_addr, wr_data);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " err"}, {31'h0, e}, {31'h0, exp_e});
    check({tag, " rdata"}, rd, ref_rdata);
    check({tag, " busy c1"}, {31'h0, b1}, 32'h1);
    check({tag, " writes"}, wr_cnt, (w && !exp_e) ? 1 : 0);
    if (w && !exp_e) begin
      check({tag, " wr cycle"}, wr_cyc, exp_lat - 1);
      check({tag, " wr addr"}, wr_addr, a >> 2);
      check({tag, " wr data"}, wr_data, ref_mem[a >> 2]);
    end
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int lat, cyc, dones, wes;
    logic e;
    logic [31:0] rd;
    logic [2:0] f;
    logic [31:0] a;

    vecs[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0, 2};
    vecs[1]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 3};
    vecs[2]  = '{1'b1, 3'b010, 32'h10,  32'h80FF7F01, 32'hDEADBEEF, 1'b0, 2};
    vecs[3]  = '{1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0, 3};
    vecs[4]  = '{1'b0, 3'b100, 32'h13,  32'h0,        32'h00000080, 1'b0, 3};
    vecs[5]  = '{1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFF80FF, 1'b0, 3};
    vecs[6]  = '{1'b0, 3'b101, 32'h10,  32'h0,        32'h00007F01, 1'b0, 3};
    vecs[7]  = '{1'b1, 3'b000, 32'h11,  32'hAA,       32'h00007F01, 1'b0, 4};
    vecs[8]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h80FFAA01, 1'b0, 3};
    vecs[9]  = '{1'b1, 3'b001, 32'h12,  32'h1234,     32'h80FFAA01, 1'b0, 4};
    vecs[10] = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h1234AA01, 1'b0, 3};
    vecs[11] = '{1'b0, 3'b010, 32'h11,  32'h0,        32'h1234AA01, 1'b1, 1};
    vecs[12] = '{1'b1, 3'b001, 32'h13,  32'h5555,     32'h1234AA01, 1'b1, 1};
    vecs[13] = '{1'b0, 3'b010, 32'h194, 32'h0,        32'h1234AA01, 1'b1, 1};
    vecs[14] = '{1'b0, 3'b011, 32'h0,   32'h0,        32'h1234AA01, 1'b1, 1};

    for (int i = 0; i < Words; i++) ref_mem[i] = 32'h0;
    ref_rdata = 32'h0;
    req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset done", {31'h0, done}, 32'h0);
    check("reset mem_we", {31'h0, mem_we}, 32'h0);
    check("reset rdata", rdata, 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].w, vecs[i].f, vecs[i].a, vecs[i].d, lat, e, rd);
      check($sformatf("vec%0d table rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d table err", i), {31'h0, e}, {31'h0, vecs[i].exp_err});
      check($sformatf("vec%0d table latency", i), lat, vecs[i].exp_lat);
    end
    check("word4 after table", tb_mem[4], 32'h1234AA01);

    // Reset during the WRITE of SW 0x20: no write, no done
    @(negedge clk);
    we = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'h5A5A5A5A; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("abort in write", {31'h0, mem_we}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("abort done", {31'h0, done}, 32'h0);
    check("abort busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    ref_rdata = 32'h0;
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort no late done", dones, 0);
    check("abort word8", tb_mem[8], ref_mem[8]);
    check("abort rdata cleared", rdata, 32'h0);

    // req pulsed while busy is ignored
    @(negedge clk);
    we = 1'b0; funct3 = 3'b010; addr = 32'h10; req = 1'b1;
    @(negedge clk);
    we = 1'b1; addr = 32'h24; wdata = 32'hCAFEF00D;
    dones = 0; wes = 0; lat = -1;
    for (cyc = 1; cyc <= 8; cyc++) begin
      if (cyc == 3) req = 1'b0;
      if (mem_we) wes++;
      if (done) begin
        dones++;
        if (lat < 0) lat = cyc;
      end
      @(negedge clk);
    end
    req = 1'b0;
    ref_rdata = ref_mem[4];
    check("busy-ign dones", dones, 1);
    check("busy-ign latency", lat, 3);
    check("busy-ign writes", wes, 0);
    check("busy-ign word9", tb_mem[9], ref_mem[9]);
    check("busy-ign rdata", rdata, ref_rdata);
    check("busy-ign idle", {31'h0, busy}, 32'h0);

    // Random mix against the reference model
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 15))
        0:       f = 3'b011;
        1:       f = 3'b110;
        2:       f = 3'b111;
        3, 4:    f = 3'b000;
        5, 6:    f = 3'b100;
        7, 8:    f = 3'b001;
        9, 10:   f = 3'b101;
        default: f = 3'b010;
      endcase
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else a = {$urandom_range(0, 104), 2'b00} | ($urandom_range(0, 3) & 32'h3);
      run_check($sformatf("rnd%0d", i), $urandom_range(0, 1) == 1, f, a, $urandom, lat, e, rd);
    end

    for (int i = 0; i < Words; i++) check($sformatf("final word%0d", i), tb_mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the word-addressed data memory. Accepts one load or store request at a time from the datapath and converts byte addresses to word indices. Performs read-modify-write for byte and halfword stores, and extracts with sign/zero extension for sub-word loads. Drives the memory's address, write-data and write-enable inputs, consumes its registered read output, and holds `busy` so the core can stall.

## Interface
- `MEM_WORDS`, 101: number of 32-bit words in the attached memory; valid word indices are 0..MEM_WORDS-1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: request strobe; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load; sampled with `req`.
- `funct3` in 3: RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr` in 32: byte address.
- `wdata` in 32: store data; byte/half taken from the low bits.
- `rdata` out 32: load result, extended; registered.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; 1 = misaligned, out of range, or illegal `funct3`.
- `busy` out 1: high whenever state ≠ IDLE.
- `mem_addr` out 32: word index `addr[31:2]` to memory.
- `mem_wdata` out 32: write word to memory.
- `mem_we` out 1: memory write enable.
- `mem_rdata` in 32: memory read data, valid the cycle after the address is presented.

## Operation
- FSM states: IDLE, READ, CAPTURE, WRITE, DONE.
- In IDLE with `req`=1, latch `we`, `funct3`, `addr` and `wdata`, then check the request:
  - Error if `funct3` ∈ {011, 110, 111}.
  - Error if H/HU and `addr[0]`≠0.
  - Error if W and `addr[1:0]`≠0.
  - Error if `addr[31:2]` ≥ MEM_WORDS.
  - For any error, go to DONE with `err`=1; no memory access occurs.
- Load path: IDLE → READ → CAPTURE → DONE.
  - READ: `mem_addr`=word index, `mem_we`=0.
  - CAPTURE: select a byte (lane `addr[1:0]`) or a half (lane `addr[1]`) from `mem_rdata`, little-endian. B/H sign-extend; BU/HU zero-extend; W passes through. The result is registered into `rdata`.
- SW path: IDLE → WRITE → DONE. In WRITE, `mem_we`=1 and `mem_wdata`=`wdata`.
- SB/SH path: IDLE → READ → CAPTURE → WRITE → DONE. CAPTURE registers a merge word: `mem_rdata` with the selected lane replaced by `wdata[7:0]` or `wdata[15:0]`. WRITE writes the merge word.
- DONE: `done`=1 for one cycle, then return to IDLE. `rdata` holds its value until the next completed load; stores and errors do not change it.
- `mem_we` is 1 only in WRITE and is gated by `!rst`. When not reading or writing, `mem_addr` and `mem_wdata` are 0.
- A `req` while `busy` is ignored, not queued.

## Timing
- Reset: state IDLE; `rdata`=0, `done`=0, `err`=0, `busy`=0, `mem_addr`=0, `mem_wdata`=0, `mem_we`=0.
- Latency from the cycle `req` is sampled (cycle 0) to the `done` pulse:
  - Load: cycle 3.
  - SW: cycle 2.
  - SB/SH: cycle 4.
  - Error: cycle 1.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- A new `req` is accepted at the earliest in the cycle after `done`.
- Reset mid-operation aborts in the same edge. If `rst` is high during WRITE, no memory write occurs. No `done` is produced for the aborted request.
- Back-to-back store then load to the same word: the load observes the stored value, because the write completes before the READ cycle.

## Test plan
- After reset, `busy`/`done`/`mem_we`=0 and `rdata`=0.
- Store then load a full word:
  - SW addr 0x10, wdata 0xDEADBEEF → `mem_we`=1 with `mem_addr`=4 in cycle 1, `done` in cycle 2.
  - Then LW 0x10 → `rdata`=0xDEADBEEF, `done` in cycle 3.
- Sub-word loads from word 4 = 0x80FF7F01:
  - LB 0x13 → 0xFFFFFF80.
  - LBU 0x13 → 0x00000080.
  - LH 0x12 → 0xFFFF80FF.
  - LHU 0x10 → 0x00007F01.
- Sub-word stores on word 4 = 0x80FF7F01:
  - SB 0x11, wdata 0xAA → word becomes 0x80FFAA01, `done` in cycle 4.
  - SH 0x12, wdata 0x1234 → word becomes 0x1234AA01.
- Error cases each give `done`+`err` in cycle 1, no `mem_we`, and `rdata` unchanged:
  - LW 0x11.
  - SH 0x13.
  - LW 0x194 (word 101).
  - `funct3`=011.
- Reset and busy handling:
  - Assert `rst` during WRITE of SW 0x20 → memory word 8 unchanged, no `done`.
  - A `req` pulsed while `busy` is ignored.
